// File: rtl/wreg_load_ctrl.sv
// -----------------------------------------------------------------------------
// wreg_load_ctrl
//   Load/compute sequencer for one column of ROWS weight registers wired as a
//   shift chain in the 8-bit binary-serial systolic array. A start request
//   opens a load window in which ROWS weight beats are accepted over a
//   valid/ready handshake and shifted into the chain head. The chain is then
//   held stable for the latched compute length, completion is pulsed, and
//   the block returns to idle. The chain registers live outside this block.
//
//   Optional feature macro: WREG_LOAD_CTRL_AUTO_CLR_EN
//     defined   - the DONE cycle also pulses w_clr, so every sequence ends
//                 with a zeroed chain and w_stable drops after DONE.
//     undefined - weights persist; w_stable stays high in IDLE until the
//                 next accepted start or a clr_req.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin load+compute sequence (sampled in IDLE only)
//   clr_req  in   abort/clear request, honoured in any state
//   cmp_len  in   compute-phase length in cycles, latched on accepted start
//   i_valid  in   weight beat valid
//   i_data   in   signed weight beat; first beat ends in the last row
//   i_ready  out  weight beat ready (combinational from state)
//   w_en     out  chain shift enable (registered)
//   w_clr    out  chain synchronous clear (registered)
//   w_data   out  signed data into chain head (registered)
//   w_stable out  chain holds a complete weight set
//   busy     out  sequencer not idle
//   done     out  one-cycle pulse at end of compute phase
// -----------------------------------------------------------------------------
module wreg_load_ctrl #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr_req,
  input  logic [CNTW-1:0]  cmp_len,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             i_ready,
  output logic             w_en,
  output logic             w_clr,
  output logic [WIDTH-1:0] w_data,
  output logic             w_stable,
  output logic             busy,
  output logic             done
);

  // A single-row chain still needs a 1-bit counter to stay legal.
  localparam int BW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMP, DONE} state_t;

  state_t            state, state_nx;
  logic [BW-1:0]     beat_cnt, beat_cnt_nx;
  logic [CNTW-1:0]   cmp_cnt, cmp_cnt_nx;
  logic [CNTW-1:0]   cmp_len_q, cmp_len_nx;
  logic              w_en_nx, w_clr_nx, w_stable_nx, done_nx;
  logic [WIDTH-1:0]  w_data_nx;

  // Last compute cycle; a zero length behaves exactly like a length of one.
  function automatic logic comp_last(input logic [CNTW-1:0] cnt,
                                     input logic [CNTW-1:0] len);
    if (len == '0) return (cnt == '0);
    else           return (cnt == (len - CNTW'(1)));
  endfunction

  assign i_ready = (state == LOAD);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx    = state;
    beat_cnt_nx = beat_cnt;
    cmp_cnt_nx  = cmp_cnt;
    cmp_len_nx  = cmp_len_q;
    w_en_nx     = 1'b0;
    w_clr_nx    = 1'b0;
    w_data_nx   = w_data;
    w_stable_nx = w_stable;
    done_nx     = 1'b0;

    if (clr_req) begin
      // Abort wins over everything; an in-flight beat is simply not loaded.
      state_nx    = IDLE;
      beat_cnt_nx = '0;
      cmp_cnt_nx  = '0;
      w_clr_nx    = 1'b1;
      w_stable_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx    = LOAD;
            cmp_len_nx  = cmp_len;
            beat_cnt_nx = '0;
            cmp_cnt_nx  = '0;
            w_stable_nx = 1'b0;
          end
        end
        LOAD: begin
          w_stable_nx = 1'b0;
          if (i_valid) begin
            w_en_nx   = 1'b1;
            w_data_nx = i_data;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt_nx = '0;
              cmp_cnt_nx  = '0;
              state_nx    = COMP;
            end else begin
              beat_cnt_nx = beat_cnt + BW'(1);
            end
          end
        end
        COMP: begin
          // Registered, so it rises one cycle after the final w_en pulse.
          w_stable_nx = 1'b1;
          if (comp_last(cmp_cnt, cmp_len_q)) begin
            cmp_cnt_nx = '0;
            state_nx   = DONE;
            done_nx    = 1'b1;
`ifdef WREG_LOAD_CTRL_AUTO_CLR_EN
            w_clr_nx   = 1'b1;
`endif
          end else begin
            cmp_cnt_nx = cmp_cnt + CNTW'(1);
          end
        end
        DONE: begin
          state_nx = IDLE;
`ifdef WREG_LOAD_CTRL_AUTO_CLR_EN
          w_stable_nx = 1'b0;
`else
          w_stable_nx = 1'b1;
`endif
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // ---- register stage: state, counters and all chain-facing outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      cmp_cnt   <= '0;
      cmp_len_q <= '0;
      w_en      <= 1'b0;
      w_clr     <= 1'b0;
      w_data    <= '0;
      w_stable  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      beat_cnt  <= beat_cnt_nx;
      cmp_cnt   <= cmp_cnt_nx;
      cmp_len_q <= cmp_len_nx;
      w_en      <= w_en_nx;
      w_clr     <= w_clr_nx;
      w_data    <= w_data_nx;
      w_stable  <= w_stable_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_wreg_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wreg_load_ctrl
//   Directed bench for wreg_load_ctrl (WIDTH=8, ROWS=4, CNTW=16): full load and
//   compute sequence, gapped beats with signed data, zero compute length with
//   ignored start, mid-load abort, start+clear collision, and async reset.
// -----------------------------------------------------------------------------
module tb_wreg_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        clr_req;
  logic [15:0] cmp_len;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        i_ready;
  logic        w_en;
  logic        w_clr;
  logic [7:0]  w_data;
  logic        w_stable;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

`ifdef WREG_LOAD_CTRL_AUTO_CLR_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  wreg_load_ctrl #(.WIDTH(8), .ROWS(4), .CNTW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clr_req  (clr_req),
    .cmp_len  (cmp_len),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .i_ready  (i_ready),
    .w_en     (w_en),
    .w_clr    (w_clr),
    .w_data   (w_data),
    .w_stable (w_stable),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] bv [4];
    logic [7:0] last_d;
    int pulses;
    logic v;

    bv[0] = 8'hFB; bv[1] = 8'h06; bv[2] = 8'hF9; bv[3] = 8'h08;  // -5, 6, -7, 8
    rst_n = 1'b0; start = 1'b0; clr_req = 1'b0; cmp_len = '0;
    i_valid = 1'b0; i_data = '0;
    tick();
    chk("rst_i_ready", i_ready, 0);
    chk("rst_w_en", w_en, 0);
    chk("rst_w_clr", w_clr, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_w_stable", w_stable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // ---- full sequence: beats 1..4 back-to-back, cmp_len=3 ----
    cmp_len = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("s1_busy", busy, 1);
    chk("s1_i_ready", i_ready, 1);
    chk("s1_w_en_idle", w_en, 0);
    for (int b = 1; b <= 4; b++) begin
      i_valid = 1'b1; i_data = 8'(b);
      tick();
      chk("s1_w_en", w_en, 1);
      chk("s1_w_data", w_data, 32'(b));
    end
    i_valid = 1'b0;
    chk("s1_comp_i_ready", i_ready, 0);
    chk("s1_stable_early", w_stable, 0);
    chk("s1_done_c0", done, 0);
    tick();
    chk("s1_w_en_off", w_en, 0);
    chk("s1_stable_rise", w_stable, 1);
    chk("s1_done_c1", done, 0);
    tick();
    chk("s1_done_c2", done, 0);
    tick();
    chk("s1_done", done, 1);
    chk("s1_done_stable", w_stable, 1);
    chk("s1_done_w_clr", w_clr, 32'(AUTO));
    chk("s1_done_busy", busy, 1);
    tick();
    chk("s1_idle_done", done, 0);
    chk("s1_idle_busy", busy, 0);
    chk("s1_idle_w_clr", w_clr, 0);
    chk("s1_idle_stable", w_stable, 32'(!AUTO));
    tick();
    chk("s1_idle_stable2", w_stable, 32'(!AUTO));

    // ---- gapped beats -5,6,-7,8 with i_valid toggling, cmp_len=2 ----
    cmp_len = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("s2_stable_drop", w_stable, 0);
    pulses = 0;
    last_d = 8'h04;
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0);
      i_valid = v;
      i_data = v ? bv[i/2] : 8'h55;
      if (v) last_d = bv[i/2];
      tick();
      if (w_en) pulses++;
      chk("s2_w_en", w_en, 32'(v));
      chk("s2_w_data", w_data, 32'(last_d));
    end
    chk("s2_pulses", pulses, 4);
    i_valid = 1'b1; i_data = 8'h77;   // ignored outside LOAD
    tick();
    chk("s2_done", done, 1);
    chk("s2_w_en_comp", w_en, 0);
    chk("s2_w_data_hold", w_data, 32'h08);
    i_valid = 1'b0;
    tick();
    chk("s2_idle_busy", busy, 0);

    // ---- cmp_len=0 -> one COMP cycle; start during COMP ignored ----
    cmp_len = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      i_valid = 1'b1; i_data = 8'(10 + b);
      tick();
    end
    i_valid = 1'b0;
    chk("s3_w_data", w_data, 32'd13);
    chk("s3_comp_done", done, 0);
    start = 1'b1; cmp_len = 16'd9;
    tick();
    chk("s3_done", done, 1);
    chk("s3_busy", busy, 1);
    chk("s3_no_reload", i_ready, 0);
    start = 1'b0;
    tick();
    chk("s3_idle_busy", busy, 0);
    chk("s3_idle_done", done, 0);

    // ---- abort after 2 of 4 beats, clr_req with i_valid ----
    cmp_len = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    i_valid = 1'b1; i_data = 8'd21; tick();
    i_data = 8'd22; tick();
    i_data = 8'd23; clr_req = 1'b1;
    tick();
    chk("s4_w_en_drop", w_en, 0);
    chk("s4_w_clr", w_clr, 1);
    chk("s4_w_data", w_data, 32'd22);
    chk("s4_busy", busy, 0);
    chk("s4_i_ready", i_ready, 0);
    chk("s4_stable", w_stable, 0);
    clr_req = 1'b0; i_valid = 1'b0;
    tick();
    chk("s4_w_clr_off", w_clr, 0);

    // ---- start and clr_req together in IDLE ----
    start = 1'b1; clr_req = 1'b1;
    tick();
    chk("s5_w_clr", w_clr, 1);
    chk("s5_busy", busy, 0);
    chk("s5_i_ready", i_ready, 0);
    start = 1'b0; clr_req = 1'b0; i_valid = 1'b1; i_data = 8'h3C;
    tick();
    chk("s5_w_clr_off", w_clr, 0);
    chk("s5_idle_valid_ignored", w_en, 0);
    chk("s5_i_ready2", i_ready, 0);
    i_valid = 1'b0;

    // ---- async reset mid-LOAD ----
    cmp_len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    i_valid = 1'b1; i_data = 8'd31;
    tick();
    chk("s6_w_en_pre", w_en, 1);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("s6_w_en", w_en, 0);
    chk("s6_w_data", w_data, 0);
    chk("s6_busy", busy, 0);
    chk("s6_i_ready", i_ready, 0);
    chk("s6_w_stable", w_stable, 0);
    chk("s6_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("s6_after_busy", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
